serial_nibble_adder_32bit: RTL and testbench
============================================

# serial_nibble_adder_32bit

Multi-cycle 32-bit adder, the additive counterpart of the 32-bit ripple-carry subtractor. It accepts X, Y and c_in through a valid/ready handshake and adds one 4-bit nibble per clock, LSB nibble first, through a single registered 4-bit ripple stage. After 8 cycles it presents S and c_out until the consumer accepts them. It sits in the arithmetic lab datapath wherever an area-cheap adder with handshake flow control is needed in place of the 8-stage combinational chain.

## Interface
- No parameters. Width is fixed at 32 bits, processed as 8 nibbles of 4 bits.
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- X  in  32  augend
- Y  in  32  addend
- c_in  in  1  carry into bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- S  out  32  sum
- c_out  out  1  carry out of bit 31
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, the block latches X, Y and c_in into operand shift registers XR, YR and carry register CR.
  - It clears nibble counter cnt=0 and moves to BUSY.
- BUSY:
  - Each cycle, the 4-bit stage adds XR[3:0] + YR[3:0] + CR.
  - The 4-bit sum is written into S at nibble position cnt, i.e. S[4*cnt+3:4*cnt].
  - The stage carry is written to CR.
  - XR and YR shift right by 4.
  - cnt increments.
  - When cnt==7, the block moves to DONE and c_out takes the final carry.
- DONE:
  - out_valid=1 and S, c_out (and ovf) are held stable.
  - When out_ready is high, the block moves to IDLE.
- in_ready is high only in IDLE. in_valid is ignored in BUSY and DONE, so no operand capture happens there.
- Arithmetic is {c_out,S} = X + Y + c_in, unsigned and modulo 2^33. No saturation.
- A new operand transfer is not accepted in the same cycle as the result handshake. One IDLE cycle always separates results.
- S is cleared when operands are captured. Nibbles not yet computed read 0 while in BUSY.

## Timing
- Reset values: in_ready=1, out_valid=0, S=0, c_out=0, ovf=0; FSM is in IDLE with cnt=0.
- Reset asserted in any state clears everything within the same cycle (asynchronous). Any partial result is discarded and no out_valid is produced.
- Latency:
  - Input handshake at rising edge E0.
  - Nibbles 0..7 are computed on edges E1..E8.
  - out_valid goes high after E8.
- Throughput is at best one result per 10 cycles: capture, 8 BUSY, DONE with out_ready high.
- out_valid stays high, with stable outputs, for as long as out_ready is low. There is no timeout.
- All outputs come directly from registers. There is no combinational path from inputs to outputs except none: in_ready is a function of state only.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - ovf = (X[31]==Y[31]) && (S[31]!=X[31]), registered on the final BUSY cycle alongside c_out. X[31] and Y[31] come from a sign flop captured at E0.
  - ovf is valid only while out_valid=1 and resets to 0.
- Undefined: no ovf port, no sign flops. All other behaviour is identical.

## Structure
- Shared package:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - NIBBLE_W=4, NUM_NIBBLES=8, CNT_W=3.
- One sub-module, ripple_carry_adder_4bit: combinational 4 full adders with carry chain, ports X[3:0], Y[3:0], c_in, S[3:0], c_out. Instantiated once.
- Top level holds the FSM, counter, shift registers, carry flop and result register.

## Test plan
- Basic add: X=0x0000_0001, Y=0x0000_0001, c_in=0 -> S=0x0000_0002, c_out=0. out_valid rises exactly 8 edges after the input handshake.
- Full ripple: X=0xFFFF_FFFF, Y=0x0000_0001, c_in=0 -> S=0x0000_0000, c_out=1. Also c_in=1 with X=0xFFFF_FFFF, Y=0 gives the same result.
- Overflow (macro on): X=0x7FFF_FFFF, Y=0x0000_0001 -> S=0x8000_0000, c_out=0, ovf=1. X=0x8000_0000, Y=0x8000_0000 -> S=0, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> S, c_out stable, in_ready=0, no capture. Release -> IDLE, then the new operands are captured.
- Reset mid-operation: assert rst at BUSY cnt=4 -> all outputs 0 immediately, IDLE after deassert. The next transaction X=0x1234_5678, Y=0x1111_1111 gives S=0x2345_6789.
- Random back-to-back: 1000 random X/Y/c_in with random out_ready stalls -> every result matches X+Y+c_in. Exactly one result per accepted input, in order.

Source files
------------

// File: rtl/serial_nibble_adder_32bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_adder_32bit_pkg
// Description : Shared types and constants for the nibble-serial 32-bit adder.
//               FSM encoding, nibble geometry and a signed-overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_nibble_adder_32bit_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int NUM_NIBBLES = 8;
  localparam int CNT_W       = 3;
  localparam int DATA_W      = NIBBLE_W * NUM_NIBBLES;

  // Last nibble index; reaching it ends the BUSY phase.
  localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: like-signed operands producing a result
  // whose sign differs from them.
  function automatic logic signed_ovf(input logic xs, input logic ys, input logic s_msb);
    return (xs == ys) && (s_msb != xs);
  endfunction

endpackage : serial_nibble_adder_32bit_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder_4bit
// Description : Combinational 4-bit adder built from four full adders with
//               a rippling carry chain. Used as the per-cycle nibble stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder_4bit
  import serial_nibble_adder_32bit_pkg::*;
(
  input  logic [NIBBLE_W-1:0] X,
  input  logic [NIBBLE_W-1:0] Y,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] S,
  output logic                c_out
);

  // w_c[i] is the carry into bit i; w_c[NIBBLE_W] leaves the stage.
  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    logic w_p;
    assign w_p        = X[i] ^ Y[i];
    assign S[i]       = w_p ^ w_c[i];
    assign w_c[i + 1] = (X[i] & Y[i]) | (w_c[i] & w_p);
  end

  assign c_out = w_c[NIBBLE_W];

endmodule : ripple_carry_adder_4bit
`default_nettype wire

// File: rtl/serial_nibble_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_adder_32bit
// Description : Multi-cycle 32-bit adder. Operands are taken through a
//               valid/ready handshake, summed one nibble per clock (LSB
//               nibble first) through a single 4-bit ripple stage, and the
//               sum/carry are held until the consumer accepts them.
//               Optional macro SERIAL_ADDER_OVF_EN adds the signed overflow
//               output ovf and the operand sign flops that feed it.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_adder_32bit
  import serial_nibble_adder_32bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] S,
  output logic              c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_xr;
  logic [DATA_W-1:0]  r_yr;
  logic               r_cr;
  logic [DATA_W-1:0]  r_s;
  logic               r_c_out;
  logic               r_in_ready;
  logic               r_out_valid;

`ifdef SERIAL_ADDER_OVF_EN
  logic               r_xs;
  logic               r_ys;
  logic               r_ovf;
`endif

  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_c;

  // Single shared nibble stage: always looks at the low nibble of the
  // operand shift registers and the running carry.
  ripple_carry_adder_4bit u_rca (
    .X     (r_xr[NIBBLE_W-1:0]),
    .Y     (r_yr[NIBBLE_W-1:0]),
    .c_in  (r_cr),
    .S     (w_nib_sum),
    .c_out (w_nib_c)
  );

  // FSM with counter, operand shifters, carry flop and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_xr        <= '0;
      r_yr        <= '0;
      r_cr        <= 1'b0;
      r_s         <= '0;
      r_c_out     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_xs        <= 1'b0;
      r_ys        <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_xr       <= X;
            r_yr       <= Y;
            r_cr       <= c_in;
            r_cnt      <= '0;
            // Fresh result: nibbles not yet computed read as zero.
            r_s        <= '0;
            r_c_out    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
`ifdef SERIAL_ADDER_OVF_EN
            r_xs       <= X[DATA_W-1];
            r_ys       <= Y[DATA_W-1];
            r_ovf      <= 1'b0;
`endif
          end
        end

        ST_BUSY: begin
          r_s[{r_cnt, 2'b00} +: NIBBLE_W] <= w_nib_sum;
          r_cr  <= w_nib_c;
          r_xr  <= r_xr >> NIBBLE_W;
          r_yr  <= r_yr >> NIBBLE_W;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_NIBBLE) begin
            r_c_out     <= w_nib_c;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // The stage sum MSB here is S[31].
            r_ovf       <= signed_ovf(r_xs, r_ys, w_nib_sum[NIBBLE_W-1]);
`endif
          end
        end

        ST_DONE: begin
          // Result handshake; new operands wait for the following IDLE cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign c_out     = r_c_out;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule : serial_nibble_adder_32bit
`default_nettype wire

// File: tb/tb_serial_nibble_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_nibble_adder_32bit
// Description : Self-checking bench for serial_nibble_adder_32bit. Directed
//               corner cases, backpressure, asynchronous reset mid-operation
//               and randomized transactions against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_nibble_adder_32bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_nibble_adder_32bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .c_out     (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 33-bit unsigned sum of the operands and carry-in.
  function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  // Reference: signed overflow of the 32-bit result.
  function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci);
    logic signed [33:0] sx;
    logic signed [33:0] sy;
    logic signed [33:0] tot;
    sx  = {{2{x[31]}}, x};
    sy  = {{2{y[31]}}, y};
    tot = sx + sy + {33'd0, ci};
    return (tot > 34'sd2147483647) || (tot < -34'sd2147483648);
  endfunction

  // One complete transaction. With pre set, the next operands are driven
  // with in_valid high during the DONE stall so their capture follows release.
  task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         input int stall, input bit pre,
                         input logic [31:0] nx, input logic [31:0] ny, input logic nci);
    int k;
    logic [32:0] e;
    e         = ref_sum(x, y, ci);
    out_ready = 1'b0;
    X         = x;
    Y         = y;
    c_in      = ci;
    in_valid  = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check_eq("in_ready_timeout", in_ready, 1);
    tick();                                   // E0: capture
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
    c_in     = 1'($urandom);
    check_eq("busy_in_ready", in_ready, 0);
    check_eq("busy_out_valid", out_valid, 0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
      if (k == 4) check_eq("partial_S", S, {16'h0, e[15:0]});
    end
    check_eq("latency", k, 8);
    check_eq("S", S, e[31:0]);
    check_eq("c_out", c_out, e[32]);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("ovf", ovf, ref_ovf(x, y, ci));
`endif
    if (pre) begin
      X        = nx;
      Y        = ny;
      c_in     = nci;
      in_valid = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_S", S, e[31:0]);
      check_eq("hold_c_out", c_out, e[32]);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("release_valid", out_valid, 0);
    check_eq("release_in_ready", in_ready, 1);
    check_eq("release_S_kept", S, e[31:0]);
  endtask

  initial begin
    int k;
    logic [31:0] rx;
    logic [31:0] ry;
    logic        rc;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    c_in      = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_S", S, 0);
    check_eq("rst_c_out", c_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("rst_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed corner cases.
    run_txn(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b0, '0, '0, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 1'b0, '0, '0, 1'b0);
    check_eq("cin_ripple_S", S, 32'h0000_0000);
    run_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    check_eq("ovf_pos_S", S, 32'h8000_0000);
    run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    check_eq("ovf_neg_c_out", c_out, 1);

    // Backpressure with next operands offered during DONE.
    run_txn(32'hA5A5_0F0F, 32'h1234_FFFF, 1'b1, 5, 1'b1,
            32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    run_txn(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset in the middle of BUSY (cnt == 4).
    X        = 32'hCAFE_1234;
    Y        = 32'h8765_4321;
    c_in     = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_S", S, 0);
    check_eq("midrst_c_out", c_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (12) begin
      tick();
      if (out_valid) k++;
    end
    check_eq("midrst_no_result", k, 0);
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0, '0, '0, 1'b0);
    check_eq("post_rst_S", S, 32'h2345_6789);

    // Randomized transactions with random stalls and chained offers.
    rx = $urandom;
    ry = $urandom;
    rc = 1'($urandom);
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] nx;
      logic [31:0] ny;
      logic        nc;
      bit          pre;
      nx  = $urandom;
      ny  = $urandom;
      nc  = 1'($urandom);
      pre = 1'($urandom);
      run_txn(rx, ry, rc, int'($urandom_range(0, 3)), pre, nx, ny, nc);
      rx = nx;
      ry = ny;
      rc = nc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_nibble_adder_32bit
`default_nettype wire
